half_minmax_reduce: RTL and testbench

//  Streaming min/max reduction over half-precision (binary16) values, sitting directly downstream of
//  the 16-bit float compare stage. It uses two float_compare_16bit instances (less-than encoding of
//  fpu_cmp_rm_t) to update a running minimum and maximum. On the element flagged last it presents
//  one result beat with a valid/ready handshake, for vector FMIN/FMAX reductions.

---
 rtl/half_minmax_reduce_if.sv | 28 ++
 rtl/half_minmax_reduce.sv | 130 +++++++++++++
 tb/tb_half_minmax_reduce.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/half_minmax_reduce_if.sv
// Handshake bundle for the binary16 min/max reducer: element input stream
// and the single-beat result output.
interface half_minmax_reduce_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_min;
   logic [15:0]      out_max;
   logic [CNT_W-1:0] out_count;
   logic             out_nan;

   // Producer/consumer side (drives elements, accepts results)
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_min, out_max, out_count, out_nan
   );

   // Reducer side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_min, out_max, out_count, out_nan
   );
endinterface

// File: rtl/half_minmax_reduce.sv
// Streaming FMIN/FMAX reduction over binary16 elements. A running min and
// max are kept with two less-than comparators; the element flagged last
// closes the stream and the result is presented as one valid/ready beat.

// Ordered less-than on binary16: NaN operands never compare less, and
// +0/-0 compare equal. Infinities fall out of the sign/magnitude ordering.
module float_compare_16bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic        lt_o
);
   logic a_nan, b_nan, both_zero, mag_lt, mag_gt;

   // Sign/magnitude ordering with NaN and signed-zero exclusions
   always_comb begin
      a_nan     = (&a_i[14:10]) & (|a_i[9:0]);
      b_nan     = (&b_i[14:10]) & (|b_i[9:0]);
      both_zero = ~(|a_i[14:0]) & ~(|b_i[14:0]);
      mag_lt    = a_i[14:0] < b_i[14:0];
      mag_gt    = a_i[14:0] > b_i[14:0];
      lt_o      = ~a_nan & ~b_nan & ~both_zero &
                  ((a_i[15] & ~b_i[15]) |
                   (~a_i[15] & ~b_i[15] & mag_lt) |
                   (a_i[15] & b_i[15] & mag_gt));
   end
endmodule

module half_minmax_reduce #(
   parameter int CNT_W = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   half_minmax_reduce_if.slave        bus
);
   localparam logic [15:0] HALF_NAN = 16'h7E00;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      min_q, min_d, max_q, max_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nan_q, nan_d;
   // Set while every element seen so far is NaN; the next ordinary value
   // then loads both min and max.
   logic             empty_q, empty_d;

   logic accept, in_nan, in_zero, d_lt_min, max_lt_d;

   assign bus.in_ready  = (state_q != DONE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_min   = min_q;
   assign bus.out_max   = max_q;
   assign bus.out_count = cnt_q;
   assign bus.out_nan   = nan_q;

   assign accept  = bus.in_valid & bus.in_ready;
   assign in_nan  = (&bus.in_data[14:10]) & (|bus.in_data[9:0]);
   assign in_zero = ~(|bus.in_data[14:0]);

   float_compare_16bit u_cmp_min (.a_i(bus.in_data), .b_i(min_q), .lt_o(d_lt_min));
   float_compare_16bit u_cmp_max (.a_i(max_q), .b_i(bus.in_data), .lt_o(max_lt_d));

   // Next-state and datapath update for the reduction FSM
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      nan_d   = nan_q;
      empty_d = empty_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               min_d   = in_nan ? HALF_NAN : bus.in_data;
               max_d   = in_nan ? HALF_NAN : bus.in_data;
               empty_d = in_nan;
               nan_d   = in_nan;
               cnt_d   = CNT_W'(1);
               state_d = bus.in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
               if (in_nan) begin
                  nan_d = 1'b1;
               end else if (empty_q) begin
                  min_d   = bus.in_data;
                  max_d   = bus.in_data;
                  empty_d = 1'b0;
               end else begin
                  // The comparator sees +0 == -0, so zero ties pick the sign here
                  if (in_zero && ~(|min_q[14:0]))
                     min_d = {bus.in_data[15] | min_q[15], 15'h0000};
                  else if (d_lt_min)
                     min_d = bus.in_data;
                  if (in_zero && ~(|max_q[14:0]))
                     max_d = {bus.in_data[15] & max_q[15], 15'h0000};
                  else if (max_lt_d)
                     max_d = bus.in_data;
               end
               if (bus.in_last) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         min_q   <= HALF_NAN;
         max_q   <= HALF_NAN;
         cnt_q   <= '0;
         nan_q   <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
         nan_q   <= nan_d;
         empty_q <= empty_d;
      end
   end
endmodule

// File: tb/tb_half_minmax_reduce.sv
// Directed bench for half_minmax_reduce: main instance with CNT_W=8 and a
// second instance with CNT_W=2 for counter saturation.
module tb_half_minmax_reduce;
   logic CLK = 1'b0;
   logic RST;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 CLK = ~CLK;

   half_minmax_reduce_if #(.CNT_W(8)) ifa ();
   half_minmax_reduce_if #(.CNT_W(2)) ifb ();

   half_minmax_reduce #(.CNT_W(8)) dut  (.CLK(CLK), .RST(RST), .bus(ifa.slave));
   half_minmax_reduce #(.CNT_W(2)) dut2 (.CLK(CLK), .RST(RST), .bus(ifb.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   // One element on the main instance; in_ready must be high when offered
   task automatic send(input logic [15:0] d, input logic last);
      chk("in_ready_before_send", 32'(ifa.in_ready), 32'd1);
      ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_last = last;
      tick();
      ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
   endtask

   task automatic send2(input logic [15:0] d, input logic last);
      ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_last = last;
      tick();
      ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                             input logic [7:0] cnt, input logic nan);
      chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
      chk({tag, "_min"},   32'(ifa.out_min),   32'(mn));
      chk({tag, "_max"},   32'(ifa.out_max),   32'(mx));
      chk({tag, "_count"}, 32'(ifa.out_count), 32'(cnt));
      chk({tag, "_nan"},   32'(ifa.out_nan),   32'(nan));
   endtask

   task automatic retire(input string tag);
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      chk({tag, "_retired_valid"}, 32'(ifa.out_valid), 32'd0);
      chk({tag, "_retired_ready"}, 32'(ifa.in_ready),  32'd1);
   endtask

   initial begin
      RST = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0; ifb.out_ready = 1'b0;
      tick(); tick();
      RST = 1'b0;

      // Reset state
      chk("rst_in_ready",  32'(ifa.in_ready),  32'd1);
      chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_min",       32'(ifa.out_min),   32'h7E00);
      chk("rst_max",       32'(ifa.out_max),   32'h7E00);
      chk("rst_count",     32'(ifa.out_count), 32'd0);
      chk("rst_nan",       32'(ifa.out_nan),   32'd0);

      // 1: basic stream, result valid right after the last accept
      send(16'h3C00, 1'b0);
      chk("t1_no_early_valid", 32'(ifa.out_valid), 32'd0);
      send(16'hBC00, 1'b0);
      send(16'h4000, 1'b1);
      expect_res("t1", 16'hBC00, 16'h4000, 8'd3, 1'b0);
      retire("t1");

      // 2: all-NaN stream, then signalling NaN skipped
      send(16'h7E00, 1'b1);
      expect_res("t2a", 16'h7E00, 16'h7E00, 8'd1, 1'b1);
      retire("t2a");
      send(16'h7D01, 1'b0);
      send(16'h3C00, 1'b1);
      expect_res("t2b", 16'h3C00, 16'h3C00, 8'd2, 1'b1);
      retire("t2b");

      // 3: infinities and signed zero preference
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b0);
      send(16'h7C00, 1'b0);
      send(16'hFC00, 1'b1);
      expect_res("t3a", 16'hFC00, 16'h7C00, 8'd4, 1'b0);
      retire("t3a");
      send(16'h0000, 1'b0);
      send(16'h8000, 1'b1);
      expect_res("t3b", 16'h8000, 16'h0000, 8'd2, 1'b0);
      retire("t3b");

      // 4: backpressure in DONE with a pending element
      send(16'hC000, 1'b1);
      ifa.in_valid = 1'b1; ifa.in_data = 16'h5000; ifa.in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_ready", 32'(ifa.in_ready),  32'd0);
         chk("t4_hold_min",   32'(ifa.out_min),   32'hC000);
         chk("t4_hold_count", 32'(ifa.out_count), 32'd1);
         chk("t4_hold_valid", 32'(ifa.out_valid), 32'd1);
      end
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      chk("t4_idle_ready", 32'(ifa.in_ready),  32'd1);
      chk("t4_idle_valid", 32'(ifa.out_valid), 32'd0);
      tick();
      ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
      expect_res("t4_next", 16'h5000, 16'h5000, 8'd1, 1'b0);
      retire("t4_next");

      // 5: reset mid-stream discards partial results
      send(16'h3C00, 1'b0);
      send(16'h4400, 1'b0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("t5_valid", 32'(ifa.out_valid), 32'd0);
      chk("t5_count", 32'(ifa.out_count), 32'd0);
      chk("t5_ready", 32'(ifa.in_ready),  32'd1);
      chk("t5_min",   32'(ifa.out_min),   32'h7E00);
      send(16'h4000, 1'b1);
      expect_res("t5_new", 16'h4000, 16'h4000, 8'd1, 1'b0);
      retire("t5_new");

      // 6: saturating count on the CNT_W=2 instance
      send2(16'h3C00, 1'b0);
      send2(16'h4000, 1'b0);
      send2(16'h3800, 1'b0);
      send2(16'h4200, 1'b0);
      send2(16'hB800, 1'b1);
      chk("t6_valid", 32'(ifb.out_valid), 32'd1);
      chk("t6_count", 32'(ifb.out_count), 32'd3);
      chk("t6_min",   32'(ifb.out_min),   32'hB800);
      chk("t6_max",   32'(ifb.out_max),   32'h4200);
      ifb.out_ready = 1'b1;
      tick();
      ifb.out_ready = 1'b0;
      chk("t6_retired", 32'(ifb.out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
